// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, frame FSM encoding and the default baud divider.
package uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_BAUD   = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;
   localparam int ST_PAR   = 8;

   localparam logic [15:0] UART_DEFAULT_DIV = 16'd867;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_e;

   // STATUS shows the FIFO fill level in four bits, pinned at 15 for deeper FIFOs.
   function automatic logic [3:0] cnt_disp(input logic [31:0] n);
      return (n > 32'd15) ? 4'hF : n[3:0];
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; a push while full and a pop
// while empty are ignored.
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   // Full is judged on the registered count, so a push into a full FIFO is lost
   // even when the same edge pops an entry.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on the core's data bus: TXDATA/STATUS/BAUD_DIV
// registers, TX FIFO and frame FSM. Define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_0400,
   parameter int               FIFO_DEPTH  = 8,
   parameter logic [15:0]      DEFAULT_DIV = UART_DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [WIDTH-1:0] ADDR,
   input  logic [WIDTH-1:0] WD,
   output logic [WIDTH-1:0] RD,
   output logic             Hit,
   output logic             tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_CAP = 1'b1;
`else
   localparam logic PARITY_CAP = 1'b0;
`endif

   logic [1:0]    off;
   logic          wr_data, wr_stat, wr_baud;
   logic          full, empty, pop;
   logic [7:0]    fifo_data;
   logic [CW-1:0] count;
   logic          ovf_q;
   logic [15:0]   baud_q;

   uart_state_e   state_q;
   logic          tx_q;
   logic [7:0]    shift_q;
   logic [15:0]   timer_q;
   logic [2:0]    idx_q;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par_q;
`endif

   logic          unused_bits;
   assign unused_bits = ^{ADDR[1:0], WD[WIDTH-1:16]};

   assign off     = ADDR[3:2];
   assign Hit     = (ADDR[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
   assign wr_data = MemWrite && Hit && (off == OFF_TXDATA);
   assign wr_stat = MemWrite && Hit && (off == OFF_STATUS);
   assign wr_baud = MemWrite && Hit && (off == OFF_BAUD);
   assign pop     = (state_q == S_IDLE) && !empty;
   assign bit_end = (timer_q == 16'd0);
   assign tx      = tx_q;

   uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_data),
      .pop_i   (pop),
      .wdata_i (WD[7:0]),
      .rdata_o (fifo_data),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q  <= 1'b0;
         baud_q <= DEFAULT_DIV;
      end else begin
         if (wr_data && full)
            ovf_q <= 1'b1;
         else if (wr_stat && WD[ST_OVF])
            ovf_q <= 1'b0;
         if (wr_baud) baud_q <= WD[15:0];
      end
   end

   always_comb begin
      RD = '0;
      if (Hit) begin
         case (off)
            OFF_STATUS: begin
               RD[ST_BUSY]          = (state_q != S_IDLE);
               RD[ST_FULL]          = full;
               RD[ST_EMPTY]         = empty;
               RD[ST_OVF]           = ovf_q;
               RD[ST_CNT +: 4]      = cnt_disp(32'(count));
               RD[ST_PAR]           = PARITY_CAP;
            end
            OFF_BAUD: RD[15:0] = baud_q;
            default:  RD = '0;
         endcase
      end
   end

   // The timer reloads from baud_q at each bit boundary, so a divider write only
   // shortens or lengthens bits that start after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         shift_q <= 8'd0;
         timer_q <= 16'd0;
         idx_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (state_q != S_IDLE)
            timer_q <= bit_end ? baud_q : timer_q - 16'd1;
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (!empty) begin
                  shift_q <= fifo_data;
                  timer_q <= baud_q;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_q   <= ^fifo_data;
`endif
               end
            end
            S_START: if (bit_end) begin
               state_q <= S_DATA;
               tx_q    <= shift_q[0];
               idx_q   <= 3'd0;
            end
            S_DATA: if (bit_end) begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_q <= S_PARITY;
                  tx_q    <= par_q;
`else
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
`endif
               end else begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  tx_q    <= shift_q[1];
                  idx_q   <= idx_q + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) begin
               state_q <= S_STOP;
               tx_q    <= 1'b1;
            end
`endif
            S_STOP: if (bit_end) begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vectors, directed frame
// sequences and a randomized run against a queue-based transmitter model.
module tb_uart_tx_mmio;

   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int          NB  = 11;
   localparam logic [31:0] CAP = 32'h100;
`else
   localparam int          NB  = 10;
   localparam logic [31:0] CAP = 32'h0;
`endif
   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] ADDR = 32'h100;
   logic [31:0] WD = 32'h0;
   logic [31:0] RD;
   logic        Hit;
   logic        tx;

   int checks = 0;
   int errors = 0;

   uart_tx_mmio dut (
      .clk      (clk),
      .reset    (reset),
      .MemWrite (MemWrite),
      .ADDR     (ADDR),
      .WD       (WD),
      .RD       (RD),
      .Hit      (Hit),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        hit;
   } vec_t;

   bit          s_we [MAXC];
   logic [31:0] s_a  [MAXC];
   logic [7:0]  s_d  [MAXC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
      MemWrite = we;
      ADDR     = a;
      WD       = d;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   // Line level of bit slot j of a frame: start, 8 data LSB first, [parity], stop.
   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j >= 1 && j <= 8) return b[j-1];
      if (j == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   function automatic logic [31:0] st_model(input bit busy, input int n, input bit ovf);
      logic [31:0] s;
      s      = CAP;
      s[0]   = busy;
      s[1]   = (n == DEPTH);
      s[2]   = (n == 0);
      s[3]   = ovf;
      s[7:4] = (n > 15) ? 4'hF : 4'(n);
      return s;
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < MAXC; i++) begin
         s_we[i] = 1'b0;
         s_a[i]  = 32'h400;
         s_d[i]  = 8'h00;
      end
   endtask

   // Runs the schedule one cycle per entry; the model tracks the byte queue and
   // the cycle at which the transmitter is next free, and predicts tx and STATUS.
   task automatic run_stream(input string name, input int ncyc, input int div);
      logic [7:0]  mq[$];
      logic [7:0]  b;
      logic [23:0] junk;
      bit          exp_tx [MAXC];
      int          next_free, tx_bad, st_bad, first_tx, first_st, c, len;
      bit          ovf;
      next_free = 0; tx_bad = 0; st_bad = 0; first_tx = -1; first_st = -1; ovf = 1'b0;
      len = NB * (div + 1);
      for (int i = 0; i < MAXC; i++) exp_tx[i] = 1'b1;
      for (int t = 0; t < ncyc; t++) begin
         c = mq.size();
         if (t >= next_free && c > 0) begin
            b = mq.pop_front();
            for (int k = 0; k < len; k++)
               if (t + k < MAXC) exp_tx[t+k] = frame_bit(b, k / (div + 1));
            next_free = t + len + 1;
         end
         if (s_we[t] && s_a[t] == 32'h400) begin
            if (c == DEPTH) ovf = 1'b1;
            else mq.push_back(s_d[t]);
         end
         junk = 24'($urandom);
         if (s_we[t]) cycle(1'b1, s_a[t], {junk, s_d[t]});
         else         cycle(1'b0, 32'h404, 32'h0);
         if (tx !== exp_tx[t]) begin
            tx_bad++;
            if (first_tx < 0) first_tx = t;
         end
         if (!s_we[t] && RD !== st_model(t < next_free - 1, mq.size(), ovf)) begin
            st_bad++;
            if (first_st < 0) first_st = t;
         end
      end
      check($sformatf("%s tx cycles wrong (first@%0d)", name, first_tx), tx_bad, 0);
      check($sformatf("%s status cycles wrong (first@%0d)", name, first_st), st_bad, 0);
   endtask

   initial begin
      vec_t vt[$];
      int   bad;
      int   div;
      logic e;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("tx after reset", {31'd0, tx}, 32'd1);

      vt.push_back('{1'b0, 32'h404, 32'h0,         32'h4 | CAP, 1'b1});
      vt.push_back('{1'b0, 32'h408, 32'h0,         32'h363,     1'b1});
      vt.push_back('{1'b0, 32'h100, 32'h0,         32'h0,       1'b0});
      vt.push_back('{1'b0, 32'h400, 32'h0,         32'h0,       1'b1});
      vt.push_back('{1'b0, 32'h40C, 32'h0,         32'h0,       1'b1});
      vt.push_back('{1'b1, 32'h408, 32'hABCD_0007, 32'h7,       1'b1});
      vt.push_back('{1'b0, 32'h40A, 32'h0,         32'h7,       1'b1});
      vt.push_back('{1'b1, 32'h40C, 32'hFFFF_FFFF, 32'h0,       1'b1});
      vt.push_back('{1'b1, 32'h100, 32'h0000_00AA, 32'h0,       1'b0});
      vt.push_back('{1'b0, 32'h404, 32'h0,         32'h4 | CAP, 1'b1});
      vt.push_back('{1'b1, 32'h404, 32'hFFFF_FFF7, 32'h4 | CAP, 1'b1});
      vt.push_back('{1'b0, 32'h410, 32'h0,         32'h0,       1'b0});
      vt.push_back('{1'b0, 32'h3FC, 32'h0,         32'h0,       1'b0});
      vt.push_back('{1'b1, 32'h408, 32'h0000_0003, 32'h3,       1'b1});
      foreach (vt[i]) begin
         if (vt[i].we) cycle(1'b1, vt[i].addr, vt[i].wd);
         MemWrite = 1'b0;
         ADDR     = vt[i].addr;
         #1;
         check($sformatf("vec%0d RD @%h", i, vt[i].addr), RD, vt[i].rd);
         check($sformatf("vec%0d Hit @%h", i, vt[i].addr), {31'd0, Hit}, {31'd0, vt[i].hit});
      end
      check("tx idle after vectors", {31'd0, tx}, 32'd1);

      // Single 0x55 frame at divider 3.
      clear_sched();
      s_we[0] = 1'b1; s_d[0] = 8'h55;
      run_stream("frame 0x55", 60, 3);
      ADDR = 32'h404; #1;
      check("busy cleared after 0x55", RD, 32'h4 | CAP);

      // Ten back-to-back pushes: the tenth finds the FIFO full.
      clear_sched();
      for (int i = 0; i < 10; i++) begin
         s_we[i] = 1'b1; s_d[i] = 8'(i);
      end
      run_stream("ten pushes", 9 * (NB * 4 + 1) + 20, 3);
      ADDR = 32'h404; #1;
      check("overflow sticky", RD, 32'hC | CAP);
      cycle(1'b1, 32'h404, 32'h8);
      ADDR = 32'h404; #1;
      check("overflow cleared", RD, 32'h4 | CAP);

      clear_sched();
      s_we[0] = 1'b1; s_d[0] = 8'h07;
      run_stream("frame 0x07", 60, 3);

      // Divider change during the start bit: that bit keeps 4 cycles, later bits 2.
      cycle(1'b1, 32'h400, 32'h0F);
      bad = 0;
      for (int t = 1; t <= 4 + (NB - 1) * 2 + 2; t++) begin
         if (t == 2) cycle(1'b1, 32'h408, 32'h1);
         else        cycle(1'b0, 32'h100, 32'h0);
         e = (t <= 4) ? 1'b0 : frame_bit(8'h0F, 1 + (t - 5) / 2);
         if (tx !== e) bad++;
      end
      check("baud change mid-bit", bad, 0);
      ADDR = 32'h408; #1;
      check("baud reads new value", RD, 32'h1);
      cycle(1'b1, 32'h408, 32'h3);

      // Reset during the data bits of 0xA5 with three bytes queued behind it.
      cycle(1'b1, 32'h400, 32'hA5);
      cycle(1'b1, 32'h400, 32'h01);
      cycle(1'b1, 32'h400, 32'h02);
      cycle(1'b1, 32'h400, 32'h03);
      repeat (4) cycle(1'b0, 32'h404, 32'h0);
      check("busy before reset", RD & 32'h1, 32'h1);
      reset = 1'b1;
      cycle(1'b0, 32'h404, 32'h0);
      check("tx after mid-frame reset", {31'd0, tx}, 32'd1);
      check("status after mid-frame reset", RD, 32'h4 | CAP);
      reset = 1'b0;
      bad = 0;
      for (int t = 0; t < 120; t++) begin
         cycle(1'b0, 32'h404, 32'h0);
         if (tx !== 1'b1) bad++;
      end
      check("no frames after reset", bad, 0);
      check("status idle after reset", RD, 32'h4 | CAP);
      ADDR = 32'h408; #1;
      check("baud default after reset", RD, 32'h363);

      // Randomized traffic against the model.
      div = $urandom_range(0, 2);
      cycle(1'b1, 32'h408, 32'(div));
      clear_sched();
      for (int t = 0; t < 2000; t++) begin
         if ($urandom_range(0, 11) == 0) begin
            s_we[t] = 1'b1;
            s_d[t]  = 8'($urandom);
            s_a[t]  = ($urandom_range(0, 7) == 0) ? 32'h40C : 32'h400;
         end
      end
      run_stream("random", 2000, div);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
